// File: rtl/sobel_result_writer.sv
// Sobel result frame writer: captures (address, magnitude) pairs into the
// frame buffer, forces border pixels to zero, and tracks frame completion.
module sobel_result_writer #(
   parameter int WIDTH  = 224,
   parameter int HEIGHT = 224,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              fclk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_address,
   input  logic [DATA_W-1:0] in_data,
   input  logic              clear,
   input  logic [ADDR_W-1:0] rd_address,
   output logic [DATA_W-1:0] rd_data,
   output logic              frame_done,
   output logic [ADDR_W-1:0] pixel_count,
   output logic              addr_err,
   output logic              overrun
);

   localparam int TOTAL = WIDTH * HEIGHT;
   localparam logic [ADDR_W:0] L_TOTAL = (ADDR_W+1)'(TOTAL);
   localparam logic [ADDR_W:0] L_ROW1  = (ADDR_W+1)'(WIDTH);
   localparam logic [ADDR_W:0] L_LAST  = (ADDR_W+1)'((HEIGHT-1)*WIDTH);
   localparam logic [ADDR_W-1:0] L_CMAX = ADDR_W'(WIDTH-1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [DATA_W-1:0] r_mem [TOTAL];

   logic              r_s1_vld;
   logic              r_s1_inr;
   logic [ADDR_W-1:0] r_s1_addr;
   logic [DATA_W-1:0] r_s1_data;

   logic [ADDR_W:0]   r_count;
   logic              r_addr_err;
   logic              r_overrun;
   logic [DATA_W-1:0] r_rd_data;

   logic [ADDR_W:0]   w_addr_x;
   logic [ADDR_W-1:0] w_col;
   logic              w_inr;
   logic              w_border;
   logic              w_rd_inr;
   logic              w_acc;
   logic [ADDR_W:0]   w_cnt_nxt;

   // Stage 1: range check and border classification (col via constant modulo)
   assign w_addr_x = {1'b0, in_address};
   assign w_col    = ADDR_W'(in_address % ADDR_W'(WIDTH));
   assign w_inr    = w_addr_x < L_TOTAL;
   assign w_border = (w_addr_x < L_ROW1) || (w_addr_x >= L_LAST) ||
                     (w_col == '0) || (w_col == L_CMAX);

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld  <= 1'b0;
         r_s1_inr  <= 1'b0;
         r_s1_addr <= '0;
         r_s1_data <= '0;
      end else begin
         r_s1_vld  <= in_valid && !clear;
         r_s1_inr  <= w_inr;
         r_s1_addr <= in_address;
         r_s1_data <= w_border ? '0 : in_data;
      end
   end

   // Stage 2: commit; a clear also drops whatever is in flight
   assign w_acc     = r_s1_vld && r_s1_inr && (r_state != DONE) && !clear;
   assign w_cnt_nxt = r_count + 1'b1;

   always_ff @(posedge fclk) begin
      if (w_acc) begin
         r_mem[r_s1_addr] <= r_s1_data;
      end
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = IDLE;
      end else begin
         unique case (r_state)
            IDLE, FILL: begin
               if (w_acc) begin
                  w_state_nxt = (w_cnt_nxt == L_TOTAL) ? DONE : FILL;
               end
            end
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         r_count    <= '0;
         r_addr_err <= 1'b0;
         r_overrun  <= 1'b0;
      end else if (clear) begin
         r_count    <= '0;
         r_addr_err <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_acc && (r_count != L_TOTAL)) begin
            r_count <= w_cnt_nxt;
         end
         if (r_s1_vld && !r_s1_inr) begin
            r_addr_err <= 1'b1;
         end
         if (r_s1_vld && (r_state == DONE)) begin
            r_overrun <= 1'b1;
         end
      end
   end

   // Read port: registered, old data on a same-cycle write
   assign w_rd_inr = {1'b0, rd_address} < L_TOTAL;

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= w_rd_inr ? r_mem[rd_address] : '0;
      end
   end

   assign rd_data     = r_rd_data;
   assign frame_done  = (r_state == DONE);
   assign pixel_count = r_count[ADDR_W-1:0];
   assign addr_err    = r_addr_err;
   assign overrun     = r_overrun;

endmodule

// File: tb/tb_sobel_result_writer.sv
// Directed bench for sobel_result_writer: writes, borders, range errors,
// full-frame completion, overrun, clear and asynchronous reset.
module tb_sobel_result_writer;

   localparam int W = 224;
   localparam int H = 224;
   localparam int T = W * H;

   logic        fclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_address = '0;
   logic [7:0]  in_data = '0;
   logic        clear = 1'b0;
   logic [15:0] rd_address = '0;
   logic [7:0]  rd_data;
   logic        frame_done;
   logic [15:0] pixel_count;
   logic        addr_err;
   logic        overrun;

   logic [7:0] m [T];
   int n_tot = 0;
   int n_bad = 0;
   int v;

   sobel_result_writer #(
      .WIDTH(W), .HEIGHT(H), .ADDR_W(16), .DATA_W(8)
   ) dut (
      .fclk(fclk), .rst_n(rst_n), .in_valid(in_valid),
      .in_address(in_address), .in_data(in_data), .clear(clear),
      .rd_address(rd_address), .rd_data(rd_data),
      .frame_done(frame_done), .pixel_count(pixel_count),
      .addr_err(addr_err), .overrun(overrun)
   );

   always #5 fclk = ~fclk;

   task automatic check(input string tag, input int obs, input int exp);
      n_tot++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] px(input int a, input logic [7:0] d);
      int r, c;
      r = a / W;
      c = a % W;
      if (r == 0 || r == H-1 || c == 0 || c == W-1) return 8'h00;
      return d;
   endfunction

   function automatic logic [7:0] sd(input int a);
      return 8'((a * 7 + 3) & 255);
   endfunction

   // single write, leaves two idle cycles so the commit is visible
   task automatic wr(input int a, input logic [7:0] d, input bit upd);
      @(negedge fclk);
      in_valid = 1'b1;
      in_address = 16'(a);
      in_data = d;
      @(negedge fclk);
      in_valid = 1'b0;
      @(negedge fclk);
      if (upd) m[a] = px(a, d);
   endtask

   task automatic rd(input int a, output int r);
      rd_address = 16'(a);
      @(negedge fclk);
      r = int'(rd_data);
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge fclk);
      check("rst_cnt", int'(pixel_count), 0);
      check("rst_done", int'(frame_done), 0);
      check("rst_aerr", int'(addr_err), 0);
      check("rst_ovr", int'(overrun), 0);
      check("rst_rd", int'(rd_data), 0);
      rst_n = 1'b1;
      @(negedge fclk);

      // interior write
      wr(225, 8'h7F, 1'b1);
      check("w1_cnt", int'(pixel_count), 1);
      check("w1_done", int'(frame_done), 0);
      rd(225, v);
      check("w1_rd", v, 8'h7F);

      // column borders forced to zero
      wr(224, 8'h55, 1'b1);
      wr(447, 8'h33, 1'b1);
      check("bd_cnt", int'(pixel_count), 3);
      rd(224, v);
      check("bd_c0", v, 0);
      rd(447, v);
      check("bd_cmax", v, 0);

      // out-of-range write
      wr(T, 8'h10, 1'b0);
      check("oor_err", int'(addr_err), 1);
      check("oor_cnt", int'(pixel_count), 3);
      rd(225, v);
      check("oor_225", v, 8'h7F);
      rd(T, v);
      check("rd_oor", v, 0);

      // clear, then a full frame at one pixel per cycle
      @(negedge fclk);
      clear = 1'b1;
      @(negedge fclk);
      clear = 1'b0;
      check("clr_cnt", int'(pixel_count), 0);
      check("clr_aerr", int'(addr_err), 0);
      for (int i = 0; i < T; i++) begin
         in_valid = 1'b1;
         in_address = 16'(i);
         in_data = sd(i);
         m[i] = px(i, sd(i));
         @(negedge fclk);
      end
      in_valid = 1'b0;
      check("pre_done", int'(frame_done), 0);
      check("pre_cnt", int'(pixel_count), T-1);
      @(negedge fclk);
      check("done", int'(frame_done), 1);
      check("done_cnt", int'(pixel_count), T);

      // overrun and range error while DONE
      wr(1000, 8'hEE, 1'b0);
      check("ovr", int'(overrun), 1);
      check("ovr_cnt", int'(pixel_count), T);
      rd(1000, v);
      check("ovr_ram", v, int'(m[1000]));
      wr(T, 8'h01, 1'b0);
      check("done_aerr", int'(addr_err), 1);
      rd(225, v);
      check("fr_225", v, int'(m[225]));
      rd(0, v);
      check("fr_0", v, 0);
      rd(T-1, v);
      check("fr_last", v, 0);
      rd(30000, v);
      check("fr_30000", v, int'(m[30000]));

      // clear wins over a simultaneous write
      @(negedge fclk);
      clear = 1'b1;
      in_valid = 1'b1;
      in_address = 16'd300;
      in_data = 8'h44;
      @(negedge fclk);
      clear = 1'b0;
      in_valid = 1'b0;
      @(negedge fclk);
      check("cw_cnt", int'(pixel_count), 0);
      check("cw_done", int'(frame_done), 0);
      check("cw_ovr", int'(overrun), 0);
      check("cw_aerr", int'(addr_err), 0);
      rd(300, v);
      check("cw_300", v, int'(m[300]));

      // asynchronous reset mid-frame
      in_valid = 1'b1;
      in_address = 16'd60000;
      in_data = 8'h99;
      @(negedge fclk);
      for (int i = 0; i < 1000; i++) begin
         in_address = 16'(10000 + i);
         in_data = 8'((i * 3) & 255);
         m[10000 + i] = px(10000 + i, 8'((i * 3) & 255));
         @(negedge fclk);
      end
      in_valid = 1'b0;
      @(negedge fclk);
      check("pr_cnt", int'(pixel_count), 1000);
      check("pr_aerr", int'(addr_err), 1);
      check("pr_rd", int'(rd_data), int'(m[300]));
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_cnt", int'(pixel_count), 0);
      check("ar_aerr", int'(addr_err), 0);
      check("ar_rd", int'(rd_data), 0);
      check("ar_done", int'(frame_done), 0);
      @(negedge fclk);
      rst_n = 1'b1;
      wr(225, 8'h11, 1'b1);
      check("nf_cnt", int'(pixel_count), 1);
      rd(225, v);
      check("nf_225", v, 8'h11);
      rd(10500, v);
      check("nf_10500", v, int'(m[10500]));
      rd(300, v);
      check("nf_300", v, int'(m[300]));

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/sobel_result_writer.md
Name: sobel_result_writer

Overview:
- Receiving end of the Sobel filter's output stream. Captures each (address, magnitude) result pair and writes it into an on-chip WIDTH x HEIGHT result frame buffer.
- Provides a one-cycle-latency read port for the visualizer scan-out.
- Tracks frame completion and flags protocol errors, so that filtering and display can be sequenced.

Parameters:
- WIDTH, 224, image width in pixels (row stride of the linear address).
- HEIGHT, 224, image height in pixels.
- ADDR_W, 16, address width; WIDTH*HEIGHT must be at most 2^ADDR_W.
- DATA_W, 8, pixel width.

Ports:
- fclk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  one-cycle strobe; in_address/in_data are valid this cycle.
- in_address  input  ADDR_W  linear pixel address, row*WIDTH+col.
- in_data  input  DATA_W  filtered magnitude.
- clear  input  1  synchronous frame restart.
- rd_address  input  ADDR_W  visualizer read address.
- rd_data  output  DATA_W  read data, registered.
- frame_done  output  1  high while the frame is complete.
- pixel_count  output  ADDR_W  accepted writes in the current frame.
- addr_err  output  1  sticky; an out-of-range write address was seen.
- overrun  output  1  sticky; an in_valid arrived while in DONE.

Behaviour:
- Reset:
  - Clock and reset: one clock (fclk); reset is asynchronous and active-low (rst_n).
  - On rst_n low: state=IDLE; rd_data=0, frame_done=0, pixel_count=0, addr_err=0, overrun=0.
  - RAM contents are not cleared.
  - Reset asserted mid-frame abandons the frame; the next frame starts from IDLE with count 0.
- Write FSM states: IDLE, FILL, DONE.
  - IDLE: the first accepted in_valid performs its write, sets pixel_count=1 and moves to FILL.
  - FILL: each accepted in_valid writes RAM and increments pixel_count. When the increment makes pixel_count equal WIDTH*HEIGHT, the next state is DONE. frame_done goes high on the same edge as that final write.
  - DONE: frame_done=1. Writes are ignored and in_valid sets overrun. The block stays in DONE until clear.
- Acceptance rule:
  - A write is accepted only when in_address < WIDTH*HEIGHT.
  - An out-of-range address: no RAM write, no count change, addr_err set. This applies in any state.
- Border forcing:
  - Pixels in row 0, row HEIGHT-1, col 0 or col WIDTH-1 are stored as 0 regardless of in_data. They still count as accepted.
  - Row and col are derived by dividing in_address by WIDTH. A registered divide or a row/col tracker is acceptable.
  - Write latency must not exceed 2 cycles from in_valid.
  - Must sustain one accepted write per cycle. The filter itself delivers one every 4 cycles.
- Duplicate addresses: each is written (last value wins) and each is counted.
- clear:
  - Returns the FSM to IDLE; zeroes pixel_count, frame_done, addr_err and overrun on the next edge.
  - clear together with in_valid in the same cycle: clear wins and the pixel is dropped, with no write and no count.
- Read port:
  - rd_data is registered with exactly 1-cycle latency from rd_address.
  - rd_address >= WIDTH*HEIGHT returns 0.
  - A read of an address being written in the same cycle returns the old contents (read-before-write).
  - Reads are always permitted, in every FSM state.
- Widths: pixel_count saturates at WIDTH*HEIGHT and never wraps. The address comparison is unsigned.

Test Plan:
- Reset, then in_valid with address 225 (row1,col1) and data 0x7F. After the write latency, drive rd_address=225 -> rd_data=0x7F one cycle later; pixel_count=1; FSM in FILL.
- Write address 224 (row1,col0) with data 0x55, then address 447 (row1,col223) with data 0x33 -> both read back 0x00; pixel_count increments by 2.
- Write address 50176 with data 0x10 -> addr_err=1; pixel_count unchanged; no RAM location modified (spot-check address 0).
- Stream all 50176 addresses, one per 4 cycles -> frame_done rises on the edge of the last write; then one extra in_valid -> overrun=1, RAM unchanged.
- clear and in_valid (address 300, data 0x44) in the same cycle -> pixel_count=0, frame_done=0, flags clear, FSM in IDLE; address 300 retains its prior value.
- Pull rst_n low asynchronously at pixel_count=1000 -> outputs zero immediately without waiting for a clock edge. After release, a new frame counts from 1; earlier RAM data remains readable.
